// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Owns the fetch PC of the five-stage MIPS pipeline. Each cycle it picks the
// next PC from one of these sources: the sequential PC+4, the EX-resolved
// branch target, the ID-stage jump target, or the ID-stage jr target. It also
// honours stalls and a sticky halt request, raises IF/ID and ID/EX flushes
// when a redirect is accepted, and keeps a saturating redirect counter.
//
// Optional build macro: BRANCH_DELAY_SLOT_EN
//   defined   : delay-slot semantics. A taken branch flushes IF only.
//               A jump or jr flushes nothing.
//   undefined : a taken branch flushes IF and ID. A jump or jr flushes IF.
//
// Parameters
//   RESET_PC : PC value loaded on reset.
//   CNT_W    : width of the redirect counter.
//
// Ports
//   clk              in   clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   stall_i          in   hazard unit: hold the PC this cycle
//   halt_req_i       in   enter HALTED; stays there until reset
//   branch_valid_i   in   EX holds a resolved conditional branch
//   branch_taken_i   in   branch resolution result
//   branch_pc4_i     in   PC+4 of the EX branch
//   branch_imm_i     in   sign-extended immediate of the EX branch
//   jump_valid_i     in   ID holds j/jal
//   jump_pc4_i       in   PC+4 of the ID jump
//   jump_index_i     in   instr[25:0] of the ID jump
//   jr_valid_i       in   ID holds jr/jalr with a forwarded operand
//   jr_addr_i        in   jr target, used unmodified
//   pc_o             out  fetch address (registered)
//   pc_valid_o       out  fetch request valid (registered)
//   flush_if_o       out  squash IF/ID this cycle (combinational)
//   flush_id_o       out  squash ID/EX this cycle (combinational)
//   redirect_count_o out  accepted redirects, saturating
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             halt_req_i,
    input  logic             branch_valid_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_pc4_i,
    input  logic [31:0]      branch_imm_i,
    input  logic             jump_valid_i,
    input  logic [31:0]      jump_pc4_i,
    input  logic [25:0]      jump_index_i,
    input  logic             jr_valid_i,
    input  logic [31:0]      jr_addr_i,
    output logic [31:0]      pc_o,
    output logic             pc_valid_o,
    output logic             flush_if_o,
    output logic             flush_id_o,
    output logic [CNT_W-1:0] redirect_count_o
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             pc_valid_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0]      branch_target;
    logic [31:0]      jump_target;
    logic             branch_take;
    logic             jr_take;
    logic             jump_take;
    logic             redirect;

    // The immediate is shifted left by two. The top two bits fall off, so the
    // add is modulo 2^32 and a negative immediate branches backward.
    assign branch_target = branch_pc4_i + {branch_imm_i[29:0], 2'b00};
    assign jump_target   = {jump_pc4_i[31:28], jump_index_i, 2'b00};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        branch_take = 1'b0;
        jr_take     = 1'b0;
        jump_take   = 1'b0;
        flush_if_o  = 1'b0;
        flush_id_o  = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = halt_req_i ? ST_HALTED : ST_RUN;
            end
            ST_RUN: begin
                // Fixed priority. A taken branch is older than anything in
                // ID, so it overrides a stall. A stall does override an ID
                // jump or jr, because ID presents that jump again next cycle.
                if (halt_req_i) begin
                    state_d = ST_HALTED;
                end else if (branch_valid_i && branch_taken_i) begin
                    branch_take = 1'b1;
                    pc_d        = branch_target;
                end else if (jr_valid_i && !stall_i) begin
                    jr_take = 1'b1;
                    pc_d    = jr_addr_i;
                end else if (jump_valid_i && !stall_i) begin
                    jump_take = 1'b1;
                    pc_d      = jump_target;
                end else if (!stall_i) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        redirect = branch_take || jr_take || jump_take;
        if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_ONE;
        end

`ifdef BRANCH_DELAY_SLOT_EN
        // The delay slot sitting in ID proceeds. Only the wrong-path fetch
        // in IF is squashed, and only after a taken branch.
        flush_if_o = branch_take;
        flush_id_o = 1'b0;
`else
        flush_if_o = redirect;
        flush_id_o = branch_take;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= (state_d == ST_RUN);
            cnt_q      <= cnt_d;
        end
    end

    assign pc_o             = pc_q;
    assign pc_valid_o       = pc_valid_q;
    assign redirect_count_o = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed scenarios plus randomized episodes. The reference model keeps the
// architectural PC, a life phase (booting / running / halted) and a redirect
// tally. The counter is narrowed to 4 bits so that saturation is reachable.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pc_sequencer;

    localparam int          CW    = 4;
    localparam int          CMAX  = (1 << CW) - 1;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall, halt, bv, bt, jv, jrv;
    logic [31:0]   bpc4, bimm, jpc4, jraddr;
    logic [25:0]   jidx;
    logic [31:0]   pc;
    logic          pc_valid, flush_if, flush_id;
    logic [CW-1:0] rcount;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall),
        .halt_req_i       (halt),
        .branch_valid_i   (bv),
        .branch_taken_i   (bt),
        .branch_pc4_i     (bpc4),
        .branch_imm_i     (bimm),
        .jump_valid_i     (jv),
        .jump_pc4_i       (jpc4),
        .jump_index_i     (jidx),
        .jr_valid_i       (jrv),
        .jr_addr_i        (jraddr),
        .pc_o             (pc),
        .pc_valid_o       (pc_valid),
        .flush_if_o       (flush_if),
        .flush_id_o       (flush_id),
        .redirect_count_o (rcount)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: phase 0 = booting, 1 = running, 2 = halted
    int          m_phase;
    logic [31:0] m_pc;
    int          m_cnt;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        stall = 0; halt = 0; bv = 0; bt = 0; jv = 0; jrv = 0;
        bpc4 = 0; bimm = 0; jpc4 = 0; jidx = 0; jraddr = 0;
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pc    = RST_PC;
        m_cnt   = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_value({tag, ".pc"},    pc, m_pc);
        check_value({tag, ".valid"}, {31'b0, pc_valid}, {31'b0, (m_phase == 1)});
        check_value({tag, ".cnt"},   {28'b0, rcount}, m_cnt[31:0]);
    endtask

    // Apply the inputs that are currently driven for one clock cycle. The
    // combinational flushes are checked before the edge, and the registered
    // outputs are checked just after it.
    task automatic cycle(input string tag);
        logic e_if, e_id, redir;
        #1;
        e_if  = 0;
        e_id  = 0;
        redir = 0;
        if (m_phase == 1 && !halt) begin
            if (bv && bt) begin
                e_if = 1; e_id = !DS; redir = 1;
            end else if ((jrv || jv) && !stall) begin
                e_if = !DS; redir = 1;
            end
        end
        check_value({tag, ".fif"}, {31'b0, flush_if}, {31'b0, e_if});
        check_value({tag, ".fid"}, {31'b0, flush_id}, {31'b0, e_id});

        // Next architectural state, from the sequencing rules
        if (m_phase == 0) begin
            m_phase = halt ? 2 : 1;
        end else if (m_phase == 1) begin
            if (halt)                 m_phase = 2;
            else if (bv && bt)        m_pc = bpc4 + bimm * 32'd4;
            else if (jrv && !stall)   m_pc = jraddr;
            else if (jv && !stall)    m_pc = {jpc4[31:28], jidx, 2'b00};
            else if (!stall)          m_pc = m_pc + 32'd4;
        end
        if (redir && m_cnt < CMAX) m_cnt++;

        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // Reset is asserted between edges; its effect must be visible at once.
    task automatic do_reset();
        rst_n = 0;
        idle();
        #1;
        model_reset();
        check_outputs("rst_async");
        check_value("rst_async.fif", {31'b0, flush_if}, 32'd0);
        check_value("rst_async.fid", {31'b0, flush_id}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        check_outputs("rst_rel");
    endtask

    logic [31:0] held_pc;

    initial begin
        rst_n = 1;
        idle();
        model_reset();
        #2;
        do_reset();

        // 1. Reset release with no events: one bubble, then 0, 4, 8, C
        cycle("boot");
        check_value("boot.first_pc", pc, 32'h0);
        cycle("seq1");
        check_value("seq1.pc4", pc, 32'h4);
        cycle("seq2");
        cycle("seq3");
        check_value("seq3.pcC", pc, 32'hC);
        check_value("seq3.cnt0", {28'b0, rcount}, 32'd0);

        // 2. A taken backward branch overrides a stall
        bv = 1; bt = 1; bpc4 = 32'h100; bimm = 32'hFFFF_FFFC; stall = 1;
        cycle("br_stall");
        check_value("br_stall.target", pc, 32'hF0);
        check_value("br_stall.cnt", {28'b0, rcount}, 32'd1);
        idle();

        // 3. A stalled jump is held once, then accepted
        jv = 1; jpc4 = 32'h4000_0010; jidx = 26'h0000040; stall = 1;
        held_pc = m_pc;
        cycle("jmp_stall");
        check_value("jmp_stall.held", pc, held_pc);
        stall = 0;
        cycle("jmp_go");
        check_value("jmp_go.target", pc, 32'h4000_0100);
        idle();

        // 4. Wrap at the top of the address space
        jrv = 1; jraddr = 32'hFFFF_FFFC;
        cycle("jr_top");
        idle();
        cycle("wrap");
        check_value("wrap.pc0", pc, 32'h0);

        // 5. jr and jump together: jr wins, one count
        jrv = 1; jraddr = 32'h200; jv = 1; jpc4 = 32'h8000_0000; jidx = 26'h3FF_FFFF;
        held_pc = {28'b0, rcount};
        cycle("jr_jmp");
        check_value("jr_jmp.target", pc, 32'h200);
        check_value("jr_jmp.cnt", {28'b0, rcount}, held_pc + 32'd1);
        idle();

        // 6. A halt together with a taken branch: PC held, invalid forever
        held_pc = m_pc;
        halt = 1; bv = 1; bt = 1; bpc4 = 32'h1000; bimm = 32'h10;
        cycle("halt");
        idle();
        for (int i = 0; i < 4; i++) cycle("halted");
        check_value("halted.pc", pc, held_pc);
        check_value("halted.valid", {31'b0, pc_valid}, 32'd0);
        @(negedge clk);
        do_reset();
        check_value("halt_rst.pc", pc, RST_PC);
        cycle("halt_rst.boot");

        // 7. The counter saturates at all-ones
        jrv = 1; jraddr = 32'h300;
        for (int i = 0; i < CMAX + 3; i++) cycle("sat_fill");
        idle();
        bv = 1; bt = 1; bpc4 = 32'h40; bimm = 32'h8;
        cycle("sat_br");
        check_value("sat_br.cnt", {28'b0, rcount}, CMAX);
        check_value("sat_br.pc", pc, 32'h60);
        idle();

        // 8. Randomized episodes, each ending in a reset
        for (int ep = 0; ep < 25; ep++) begin
            @(negedge clk);
            do_reset();
            for (int c = 0; c < 120; c++) begin
                stall  = ($urandom_range(0, 3) == 0);
                halt   = ($urandom_range(0, 149) == 0);
                bv     = ($urandom_range(0, 3) == 0);
                bt     = $urandom_range(0, 1) == 1;
                bpc4   = $urandom;
                bimm   = {{16{$urandom_range(0, 1) == 1}}, 16'($urandom)};
                jv     = ($urandom_range(0, 5) == 0);
                jpc4   = $urandom;
                jidx   = 26'($urandom);
                jrv    = ($urandom_range(0, 7) == 0);
                jraddr = $urandom;
                cycle("rand");
            end
            idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the five-stage MIPS pipeline. Owns the PC register and chooses each cycle between the sequential PC+4, the EX-resolved branch target (PC+4 + (imm << 2)), and the ID-stage jump/jr target. It honours hazard-unit stalls and halt requests, issues IF/ID flushes on redirects, and counts redirects for performance debug. It sits between the hazard unit, the ID/EX branch-resolution logic and the instruction memory address port.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the redirect counter.

- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Stall  in  1  hazard unit: hold PC this cycle.
- HaltReq  in  1  enter HALTED; sticky until reset.
- BranchValid  in  1  EX stage holds a resolved conditional branch.
- BranchTaken  in  1  resolution result; ignored unless BranchValid.
- BranchPC4  in  32  PC+4 of the EX branch.
- BranchImm  in  32  sign-extended 16-bit immediate of the EX branch.
- JumpValid  in  1  ID stage holds j/jal.
- JumpPC4  in  32  PC+4 of the ID jump.
- JumpIndex  in  26  instr[25:0] of the ID jump.
- JrValid  in  1  ID stage holds jr/jalr with a forwarded operand.
- JrAddr  in  32  jr target.
- PC  out  32  fetch address, registered.
- PCValid  out  1  fetch request valid, registered.
- FlushIF  out  1  squash the IF/ID register this cycle (combinational).
- FlushID  out  1  squash the ID/EX register this cycle (combinational).
- RedirectCount  out  CNT_W  number of taken redirects, saturating.

## Operation
- States: BOOT, RUN, HALTED.
- BOOT: entered on reset. PCValid=0. Moves to RUN after one cycle; PC is unchanged.
- RUN: PCValid=1. Next PC is chosen by fixed priority:
  1. HaltReq: go to HALTED, PC held.
  2. BranchValid&BranchTaken: PC <= BranchPC4 + (BranchImm << 2).
  3. JrValid&!Stall: PC <= JrAddr.
  4. JumpValid&!Stall: PC <= {JumpPC4[31:28], JumpIndex, 2'b00}.
  5. Stall: PC held.
  6. Otherwise: PC <= PC + 4.
- A taken branch beats a simultaneous Stall. The stalled ID instruction is squashed by FlushID.
- Stall beats a same-cycle jump/jr; ID re-presents the jump next cycle.
- JrValid and JumpValid together: jr wins; count one redirect.
- HALTED: PCValid=0, PC held, flushes 0. Only reset exits.
- Arithmetic is modulo 2^32 with no overflow detection. 0xFFFF_FFFC+4 wraps to 0x0000_0000. Negative BranchImm branches backward.
- JrAddr is used unmodified; misalignment is not checked.
- FlushIF/FlushID are asserted only in RUN, in the cycle the redirect is accepted.
- RedirectCount increments on each accepted redirect (branch, jump, jr) and saturates at all-ones.

## Timing
- Reset (asynchronous assert, synchronous effect on release): PC=RESET_PC, PCValid=0, FlushIF=0, FlushID=0, RedirectCount=0, state BOOT.
- Reset asserted mid-operation immediately forces the reset values, discarding any pending redirect.
- First valid fetch of RESET_PC is on the second rising edge after reset release.
- Redirect latency: the new PC is visible one cycle after the inputs are sampled. Flushes are combinational in the sampling cycle.
- Branch penalty without a delay slot: 2 bubbles. Jump penalty: 1 bubble.

## Configuration
- BRANCH_DELAY_SLOT_EN defined: MIPS delay-slot semantics.
  - Taken branch: FlushIF=1, FlushID=0; the delay slot in ID proceeds.
  - Jump/jr: FlushIF=0, FlushID=0.
- Undefined:
  - Taken branch: FlushIF=1, FlushID=1.
  - Jump/jr: FlushIF=1, FlushID=0.
- Target computation and priority are identical in both builds.

## Test plan
- Reset release, no events -> PCValid low for 1 cycle, then PC 0x0, 0x4, 0x8, 0xC on successive cycles; RedirectCount=0.
- Branch: BranchValid=1, BranchTaken=1, BranchPC4=0x100, BranchImm=0xFFFF_FFFC, with Stall=1 -> next PC=0xF0; FlushIF=FlushID=1 (macro off) or FlushIF=1 only (macro on); RedirectCount=1.
- JumpValid=1, JumpPC4=0x4000_0010, JumpIndex=0x0000040, first with Stall=1 then 0 -> PC held once, then PC=0x4000_0100; FlushIF=1 only on the accept cycle (macro off).
- PC=0xFFFF_FFFC with no events -> next PC=0x0000_0000. JrValid and JumpValid together with JrAddr=0x200 -> PC=0x200 and one count.
- HaltReq=1 together with a taken branch -> PC held, PCValid=0 forever. Assert Reset mid-halt -> PC=RESET_PC, state BOOT.
- Force RedirectCount to all-ones, then apply a taken branch -> count stays all-ones.
